// File: rtl/argmax_pkg.sv
// Shared defaults and FSM state type for the streaming argmax sequencer.
package argmax_pkg;
  localparam int NUM_CLASSES_DEF = 10;
  localparam int SCORE_W_DEF     = 32;

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} argmax_state_t;
endpackage

// File: rtl/argmax_sequencer.sv
// Streaming argmax: one signed score per handshake, running max/index kept in
// a single compare stage, winner presented as index/one-hot/max until accepted.
module argmax_sequencer
  import argmax_pkg::*;
#(
  parameter int  NUM_CLASSES = NUM_CLASSES_DEF,
  parameter int  SCORE_W     = SCORE_W_DEF,
  localparam int IDX_W       = $clog2(NUM_CLASSES)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   score_valid,
  output logic                   score_ready,
  input  logic [SCORE_W-1:0]     score_data,
  output logic                   busy,
  output logic                   result_valid,
  input  logic                   result_ready,
  output logic [IDX_W-1:0]       result_index,
  output logic [NUM_CLASSES-1:0] result_onehot,
  output logic [SCORE_W-1:0]     result_max
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  argmax_state_t state_q, state_d;

  logic [IDX_W-1:0]       cnt_q, idx_q, idx_d;
  logic [SCORE_W-1:0]     max_q, max_d;
  logic [NUM_CLASSES-1:0] oh_d;
  logic                   xfer, last, upd;

  // Handshake outputs decode the state register only.
  assign score_ready  = (state_q == COLLECT);
  assign result_valid = (state_q == DONE);
  assign busy         = (state_q == COLLECT) || (state_q == DONE);

  assign xfer = score_valid && score_ready;
  assign last = (cnt_q == LAST_IDX);
  // First score seeds the max; afterwards strict compare so ties keep the lowest index.
  assign upd   = (cnt_q == '0) || ($signed(score_data) > $signed(max_q));
  assign max_d = upd ? score_data : max_q;
  assign idx_d = upd ? cnt_q : idx_q;
  assign oh_d  = {{(NUM_CLASSES-1){1'b0}}, 1'b1} << idx_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = COLLECT;
      COLLECT: if (xfer && last) state_d = DONE;
      DONE:    if (result_ready) state_d = start ? COLLECT : IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q         <= '0;
      idx_q         <= '0;
      max_q         <= '0;
      result_index  <= '0;
      result_onehot <= '0;
      result_max    <= '0;
    end else if (abort) begin
      cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) cnt_q <= '0;
        COLLECT: if (xfer) begin
          max_q <= max_d;
          idx_q <= idx_d;
          if (last) begin
            // Final update folds straight into the result registers on entry to DONE.
            result_index  <= idx_d;
            result_onehot <= oh_d;
            result_max    <= max_d;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: if (result_ready) cnt_q <= '0;
        default: cnt_q <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_argmax_sequencer.sv
// Randomized/directed bench for argmax_sequencer against a plain argmax model.
module tb_argmax_sequencer;
  localparam int NC = 10;
  localparam int SW = 32;
  localparam int IW = $clog2(NC);

  logic          clk, rst, start, abort, score_valid, score_ready;
  logic [SW-1:0] score_data;
  logic          busy, result_valid, result_ready;
  logic [IW-1:0] result_index;
  logic [NC-1:0] result_onehot;
  logic [SW-1:0] result_max;

  argmax_sequencer #(.NUM_CLASSES(NC), .SCORE_W(SW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .score_valid(score_valid), .score_ready(score_ready), .score_data(score_data),
    .busy(busy), .result_valid(result_valid), .result_ready(result_ready),
    .result_index(result_index), .result_onehot(result_onehot), .result_max(result_max)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic signed [SW-1:0] frame [NC];
  int                   exp_idx;
  logic [SW-1:0]        exp_max;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: first occurrence of the largest signed value.
  task automatic ref_argmax();
    logic signed [SW-1:0] best;
    best    = frame[0];
    exp_idx = 0;
    for (int i = 1; i < NC; i++)
      if (frame[i] > best) begin
        best    = frame[i];
        exp_idx = i;
      end
    exp_max = best;
  endtask

  task automatic load(input int v[NC]);
    for (int i = 0; i < NC; i++) frame[i] = v[i];
  endtask

  task automatic rand_frame();
    for (int i = 0; i < NC; i++)
      if ($urandom_range(1) == 0) frame[i] = $urandom;
      else frame[i] = $signed($urandom_range(40)) - 20;
  endtask

  task automatic begin_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("begin_busy", busy, 1);
    chk("begin_ready", score_ready, 1);
  endtask

  // Offer frame[0..n-1] with score_valid high pct% of cycles.
  task automatic feed(input int n, input int pct);
    int i = 0;
    int guard = 0;
    while (i < n && guard < 2000) begin
      score_valid = ($urandom_range(99) < pct);
      score_data  = score_valid ? frame[i] : $urandom;
      if (score_valid && score_ready) i++;
      tick();
      guard++;
      if (i < NC) chk("no_early_valid", result_valid, 0);
    end
    score_valid = 1'b0;
    chk("feed_timeout", (i == n), 1);
  endtask

  task automatic check_result(input string tag);
    logic [NC-1:0] oh;
    ref_argmax();
    oh = '0;
    oh[exp_idx] = 1'b1;
    chk({tag, "_valid"}, result_valid, 1);
    chk({tag, "_index"}, result_index, exp_idx);
    chk({tag, "_onehot"}, result_onehot, oh);
    chk({tag, "_max"}, result_max, exp_max);
  endtask

  task automatic accept();
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    chk("accept_idle", busy, 0);
    chk("accept_rv", result_valid, 0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_sready"}, score_ready, 0);
    chk({tag, "_rvalid"}, result_valid, 0);
    chk({tag, "_index"}, result_index, 0);
    chk({tag, "_onehot"}, result_onehot, 0);
    chk({tag, "_max"}, result_max, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; score_valid = 1'b0;
    score_data = '0; result_ready = 1'b0;
    #1;
    check_zero("reset");
    tick(); tick();
    rst = 1'b0;
    tick();

    // Directed frame with a tie at the max.
    load('{3, 9, 1, 7, 9, 0, 2, 5, 4, 8});
    begin_frame();
    feed(NC, 100);
    check_result("tie");
    chk("tie_idx_literal", result_index, 1);
    chk("tie_max_literal", result_max, 9);
    accept();

    // All-negative frame.
    load('{-10, -3, -7, -20, -5, -9, -4, -8, -6, -11});
    begin_frame();
    feed(NC, 100);
    check_result("neg");
    chk("neg_max_literal", result_max, 32'hFFFF_FFFD);
    accept();

    // Sparse valid, max at the last class; scores offered in IDLE are refused.
    rand_frame();
    frame[NC-1] = 32'sh7FFF_FFFF;
    score_valid = 1'b1;
    tick();
    chk("idle_no_ready", score_ready, 0);
    score_valid = 1'b0;
    begin_frame();
    feed(NC, 40);
    check_result("sparse");
    chk("sparse_idx_literal", result_index, NC - 1);

    // Stall in DONE while poking start and offering scores.
    for (int c = 0; c < 20; c++) begin
      start       = c[0];
      score_valid = 1'b1;
      score_data  = $urandom;
      tick();
      chk("hold_sready", score_ready, 0);
      chk("hold_index", result_index, exp_idx);
      chk("hold_max", result_max, exp_max);
      chk("hold_valid", result_valid, 1);
    end
    score_valid  = 1'b0;
    start        = 1'b1;
    result_ready = 1'b1;
    tick();
    start = 1'b0; result_ready = 1'b0;
    chk("b2b_busy", busy, 1);
    chk("b2b_sready", score_ready, 1);
    chk("b2b_rvalid", result_valid, 0);
    rand_frame();
    feed(NC, 70);
    check_result("b2b");
    accept();

    // Abort after 5 transfers, coincident with a transfer and start.
    rand_frame();
    for (int i = 0; i < NC; i++) frame[i] = 32'sd1000 + i;
    begin_frame();
    feed(5, 100);
    score_valid = 1'b1; score_data = frame[5]; abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0; score_valid = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_sready", score_ready, 0);
    chk("abort_rvalid", result_valid, 0);
    chk("abort_keep_index", result_index, exp_idx);
    chk("abort_keep_max", result_max, exp_max);
    rand_frame();
    begin_frame();
    feed(NC, 60);
    check_result("post_abort");
    accept();

    // Asynchronous reset mid-frame.
    rand_frame();
    begin_frame();
    feed(4, 100);
    #2 rst = 1'b1;
    #1 check_zero("async_rst");
    #1 rst = 1'b0;
    tick();
    chk("post_rst_idle", busy, 0);
    rand_frame();
    begin_frame();
    feed(NC, 50);
    check_result("post_rst");
    accept();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end
endmodule
